// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory
// Ports: clk, rst (sync, active-low); start/len begin a load; byte_valid/byte_data/byte_ready stream in bytes;
// mem_we/mem_addr/mem_wdata write instruction memory; cpu_hold keeps the CPU in reset until done;
// busy/done/err report status. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int MAX_WORDS = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , CSUM, ERR
`endif
  } state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t FIN = CSUM;
`else
  localparam state_t FIN = DONE;
`endif
  localparam logic [CNT_W-1:0] MAXW = CNT_W'(MAX_WORDS);
  state_t state, nxt;
  logic [1:0] bcnt;
  logic [CNT_W-1:0] widx, eff_len, len_cap;
  logic [23:0] acc;
  logic idle_like, take, last;
  assign len_cap = len > MAXW ? MAXW : len;
  assign take = byte_valid && byte_ready;
  assign last = widx + CNT_W'(1) == eff_len;
  assign mem_we = state == WRITE;
  assign cpu_hold = state != DONE;
  assign done = state == DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign err = state == ERR;
  assign busy = state == RECV || state == WRITE || state == CSUM;
`else
  assign err = 1'b0;
  assign busy = state == RECV || state == WRITE;
`endif
  always_comb begin
    nxt = state;
    idle_like = state == IDLE || state == DONE;
    byte_ready = state == RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
    idle_like = idle_like || state == ERR;
    byte_ready = byte_ready || state == CSUM;
`endif
    case (state)
      RECV: nxt = take && bcnt == 2'd3 ? WRITE : RECV;
      WRITE: nxt = last ? FIN : RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: nxt = take ? (byte_data == csum ? DONE : ERR) : CSUM;
`endif
      default: nxt = idle_like && start ? (len_cap == '0 ? FIN : RECV) : state;
    endcase
  end
  // acc shifts bytes in from the top so after three bytes it holds {b2,b1,b0}
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      bcnt <= '0;
      widx <= '0;
      eff_len <= '0;
      acc <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      state <= nxt;
      if (idle_like && start) begin
        eff_len <= len_cap;
        widx <= '0;
        bcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= '0;
`endif
      end
      if (state == RECV && take) begin
        bcnt <= bcnt + 2'd1;
        acc <= {byte_data, acc[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum <= csum ^ byte_data;
`endif
        if (bcnt == 2'd3) begin
          mem_wdata <= {byte_data, acc};
          mem_addr <= BASE_ADDR + (32'(widx) << 2);
        end
      end
      if (state == WRITE) widx <= widx + CNT_W'(1);
    end
  end
endmodule
